// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add a saturating back-pressure stall counter (stall_cnt).
module fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_wfull,
    output logic                  fifo_winc,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int CW = $clog2(MAXBURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW:0]     cand_w;
    logic [IDW-1:0]   nxt_ptr;
    logic             req_g;
    logic             wr;
    logic             last_beat;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    // Circular search for the first requester at or after rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_w    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_w = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            if (!sel_found && req[cand_w[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_w[IDW-1:0];
            end
        end
    end

    assign nxt_ptr   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
    assign req_g     = req[gnt_id_q];
    assign wr        = (state_q == S_BURST) && req_g && !fifo_wfull;
    assign last_beat = (beat_cnt_q == CW'(MAXBURST - 1));

    // A dropped request ends the burst even while the FIFO is full.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == S_IDLE) begin
            if (sel_found) begin
                gnt_id_d   = sel_idx;
                beat_cnt_d = '0;
                state_d    = S_BURST;
            end
        end else begin
            if (!req_g) begin
                state_d  = S_IDLE;
                rr_ptr_d = nxt_ptr;
            end else if (wr) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (last_beat) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = nxt_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign fifo_winc  = wr;
    assign ack        = wr ? (NREQ'(1) << gnt_id_q) : '0;
    assign fifo_wdata = wr ? data_arr[gnt_id_q] : '0;
    assign gnt_id     = gnt_id_q;
    assign busy       = (state_q == S_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_BURST) && req_g && fifo_wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: directed bursts, back-pressure, early drop and reset.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  fifo_wfull;
    logic                  fifo_winc;
    logic [DSIZE-1:0]      fifo_wdata;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]           stall_cnt;
`endif

    fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .gnt_id     (gnt_id),
        .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DSIZE-1:0] src_q [NREQ][$];
    int               exp_id_q [$];
    logic [DSIZE-1:0] exp_data_q [$];
    int               wcnt [NREQ];
    int               ecnt [NREQ];

    logic [NREQ-1:0]  s_ack;
    logic             s_winc;
    logic             s_busy;
    logic [IDW-1:0]   s_gid;
    logic [DSIZE-1:0] s_wdata;

    int               m_id;
    logic [DSIZE-1:0] m_data;

    function automatic logic [DSIZE-1:0] word_of(input int id, input int k);
        return DSIZE'((id << 4) | (k & 15));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) begin
                req[i] = 1'b1;
                req_data[i*DSIZE +: DSIZE] = src_q[i][0];
            end else begin
                req[i] = 1'b0;
                req_data[i*DSIZE +: DSIZE] = '0;
            end
        end
    endtask

    task automatic load(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[id].push_back(word_of(id, wcnt[id]));
            wcnt[id]++;
        end
        refresh();
    endtask

    task automatic expect_w(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            exp_id_q.push_back(id);
            exp_data_q.push_back(word_of(id, ecnt[id]));
            ecnt[id]++;
        end
    endtask

    // Snapshot the current cycle at negedge, then advance requesters after the next posedge.
    task automatic step();
        @(negedge clk);
        s_ack   = ack;
        s_winc  = fifo_winc;
        s_busy  = busy;
        s_gid   = gnt_id;
        s_wdata = fifo_wdata;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic run(input string name, input string full, input string winc, input string bsy);
        for (int c = 0; c < winc.len(); c++) begin
            fifo_wfull = (c < full.len()) ? (full[c] == "1") : 1'b0;
            step();
            chk($sformatf("%s winc c%0d", name, c), 32'(s_winc), 32'(winc[c] == "1"));
            chk($sformatf("%s busy c%0d", name, c), 32'(s_busy), 32'(bsy[c] == "1"));
        end
        fifo_wfull = 1'b0;
    endtask

    task automatic reset_checks(input string name);
        chk({name, " ack"},   32'(s_ack),   32'd0);
        chk({name, " winc"},  32'(s_winc),  32'd0);
        chk({name, " busy"},  32'(s_busy),  32'd0);
        chk({name, " gnt"},   32'(s_gid),   32'd0);
        chk({name, " wdata"}, 32'(s_wdata), 32'd0);
    endtask

    // Monitor: every write is matched against the scoreboard; invariants checked each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_wfull) chk("winc_while_full", 32'(fifo_winc), 32'd0);
            if (fifo_winc) begin
                if (exp_id_q.size() == 0) begin
                    chk("unexpected_write", 32'(fifo_winc), 32'd0);
                end else begin
                    m_id   = exp_id_q.pop_front();
                    m_data = exp_data_q.pop_front();
                    chk("sb_ack",   32'(ack),        32'(1) << m_id);
                    chk("sb_gnt",   32'(gnt_id),     32'(m_id));
                    chk("sb_wdata", 32'(fifo_wdata), 32'(m_data));
                end
            end else begin
                chk("idle_ack",   32'(ack),        32'd0);
                chk("idle_wdata", 32'(fifo_wdata), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        fifo_wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wcnt[i] = 0;
            ecnt[i] = 0;
        end
        step();
        reset_checks("rst0");
        rst = 1'b0;

        // Single requester, 6 words: 4-beat burst, gap, 2-beat burst.
        expect_w(0, 6);
        load(0, 6);
        run("t1", "", "011110110", "011110111");

        rst = 1'b1;
        step();
        reset_checks("rst1");
        rst = 1'b0;

        // All four requesting: order 0,1,2,3,0 with one gap cycle between bursts.
        expect_w(0, 4);
        expect_w(1, 4);
        expect_w(2, 4);
        expect_w(3, 4);
        expect_w(0, 4);
        load(0, 8);
        load(1, 4);
        load(2, 4);
        load(3, 4);
        run("t2", "", "01111011110111101111011110", "01111011110111101111011110");

        // Requester 2 stalled by wfull for 3 cycles after its 2nd beat.
        expect_w(2, 4);
        load(2, 4);
        run("t3", "000111000", "011000110", "011111110");

        // Requester 1 drops after 2 acks with 3 pending; 3 is granted next.
        expect_w(1, 2);
        expect_w(3, 1);
        load(1, 2);
        run("t4a_c0", "", "0", "0");
        load(3, 1);
        run("t4a", "", "1100100", "1110110");

        // Same drop again; simultaneous 0/2 afterwards must grant 2 first.
        expect_w(1, 2);
        expect_w(2, 1);
        expect_w(0, 1);
        load(1, 2);
        run("t4b_c0", "", "0", "0");
        load(0, 1);
        load(2, 1);
        run("t4b", "", "1100100100", "1110110110");

        // Reset on beat 2 of requester 3's burst; afterwards 0 wins over 3.
        expect_w(3, 2);
        expect_w(0, 1);
        expect_w(3, 2);
        load(3, 4);
        run("t5a", "", "01", "01");
        rst = 1'b1;
        run("t5b", "", "1", "1");
        rst = 1'b0;
        load(0, 1);
        step();
        reset_checks("t5_rst");
        run("t5c", "", "1001100", "1101110");

`ifdef FIFO_WR_ARB_STATS_EN
        // 20 stalled cycles mid-burst, then reset clears the counter.
        expect_w(1, 4);
        load(1, 4);
        run("t6", "00111111111111111111110000", "01000000000000000000001110",
            "01111111111111111111111110");
        chk("stall_cnt", 32'(stall_cnt), 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif

        step();
        chk("sb_empty", 32'(exp_id_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
